// File: rtl/simd_pkg.sv
// simd_pkg: shared instruction-field positions, forward-source encoding and history entry type.
package simd_pkg;
  localparam int RD_LSB  = 0;
  localparam int RS1_LSB = 5;
  localparam int RS2_LSB = 10;
  localparam int RS3_LSB = 15;
  localparam int FIELD_W = 5;
  localparam logic [2:0] FWD_SRC_WB    = 3'd0;
  localparam logic [2:0] FWD_SRC_HIST0 = 3'd1;
  typedef struct packed {
    logic               valid;
    logic [FIELD_W-1:0] addr;
    logic [127:0]       data;
  } hist_entry_t;
endpackage

// File: rtl/fwd_operand_select.sv
// fwd_operand_select: priority match of one EX source operand against live WB and the write history.
module fwd_operand_select
  import simd_pkg::*;
#(
  parameter int DATA_W      = 128,
  parameter int REG_AW      = 5,
  parameter int HIST_DEPTH  = 2,
  parameter bit ZERO_REG_EN = 1'b0
) (
  input  logic [REG_AW-1:0]            rs,
  input  logic                         used,
  input  logic                         ex_valid,
  input  logic                         wb_valid,
  input  logic [REG_AW-1:0]            wb_rd,
  input  logic [DATA_W-1:0]            wb_data,
  input  logic [HIST_DEPTH-1:0]        hist_valid,
  input  logic [HIST_DEPTH*REG_AW-1:0] hist_addr,
  input  logic [HIST_DEPTH*DATA_W-1:0] hist_data,
  output logic                         hit,
  output logic [2:0]                   src,
  output logic [DATA_W-1:0]            data
);
  logic en;
  assign en = ex_valid && used && !(ZERO_REG_EN && rs == '0);
  // Walk oldest to youngest so later (younger) matches overwrite older ones.
  always_comb begin
    hit  = 1'b0;
    src  = FWD_SRC_WB;
    data = '0;
    for (int i = HIST_DEPTH - 1; i >= 0; i--) begin
      if (en && hist_valid[i] && hist_addr[i*REG_AW +: REG_AW] == rs) begin
        hit  = 1'b1;
        src  = FWD_SRC_HIST0 + 3'(i);
        data = hist_data[i*DATA_W +: DATA_W];
      end
    end
    if (en && wb_valid && wb_rd == rs) begin
      hit  = 1'b1;
      src  = FWD_SRC_WB;
      data = wb_data;
    end
  end
endmodule

// File: rtl/forward_history_unit.sv
// forward_history_unit: forwards WB and recent retired writes to EX source operands,
// youngest write first, and counts forwarding cycles.
module forward_history_unit
  import simd_pkg::*;
#(
  parameter int DATA_W      = 128,
  parameter int REG_AW      = 5,
  parameter int NUM_SRC     = 3,
  parameter int HIST_DEPTH  = 2,
  parameter bit ZERO_REG_EN = 1'b0,
  parameter int CNT_W       = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        wb_valid,
  input  logic [REG_AW-1:0]           wb_rd,
  input  logic [DATA_W-1:0]           wb_data,
  input  logic                        ex_valid,
  input  logic [NUM_SRC*REG_AW-1:0]   ex_rs,
  input  logic [NUM_SRC-1:0]          ex_rs_used,
  output logic [NUM_SRC-1:0]          fwd_hit,
  output logic [NUM_SRC*3-1:0]        fwd_src,
  output logic [NUM_SRC*DATA_W-1:0]   fwd_data,
  output logic [CNT_W-1:0]            fwd_count,
  output logic [2:0]                  hist_occ
);
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;
  entry_t hist_q [HIST_DEPTH];
  entry_t hist_d [HIST_DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [HIST_DEPTH-1:0]        hv;
  logic [HIST_DEPTH*REG_AW-1:0] ha;
  logic [HIST_DEPTH*DATA_W-1:0] hd;
  logic [2:0] occ;
  always_comb begin
    hist_d[0] = '{valid: wb_valid, addr: wb_rd, data: wb_data};
    for (int i = 1; i < HIST_DEPTH; i++) hist_d[i] = hist_q[i-1];
    // A flush drops everything, including the write presented this cycle.
    if (flush) for (int i = 0; i < HIST_DEPTH; i++) hist_d[i].valid = 1'b0;
    cnt_d = (|fwd_hit && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_comb begin
    occ = '0;
    hv  = '0;
    ha  = '0;
    hd  = '0;
    for (int i = 0; i < HIST_DEPTH; i++) begin
      hv[i] = hist_q[i].valid;
      ha[i*REG_AW +: REG_AW] = hist_q[i].addr;
      hd[i*DATA_W +: DATA_W] = hist_q[i].data;
      occ = occ + 3'(hist_q[i].valid);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < HIST_DEPTH; i++) hist_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < HIST_DEPTH; i++) hist_q[i] <= hist_d[i];
      cnt_q <= cnt_d;
    end
  end
  for (genvar k = 0; k < NUM_SRC; k++) begin : g_sel
    fwd_operand_select #(
      .DATA_W(DATA_W), .REG_AW(REG_AW), .HIST_DEPTH(HIST_DEPTH), .ZERO_REG_EN(ZERO_REG_EN)
    ) u_sel (
      .rs        (ex_rs[k*REG_AW +: REG_AW]),
      .used      (ex_rs_used[k]),
      .ex_valid  (ex_valid),
      .wb_valid  (wb_valid),
      .wb_rd     (wb_rd),
      .wb_data   (wb_data),
      .hist_valid(hv),
      .hist_addr (ha),
      .hist_data (hd),
      .hit       (fwd_hit[k]),
      .src       (fwd_src[k*3 +: 3]),
      .data      (fwd_data[k*DATA_W +: DATA_W])
    );
  end
  assign fwd_count = cnt_q;
  assign hist_occ  = occ;
endmodule
